seq_divider: RTL



---
 rtl/seq_divider.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider.
// One quotient bit is resolved per clock; a division takes WIDTH iteration
// cycles followed by a single done cycle, independent of operand values.
// Results and the divide-by-zero flag are held until the next done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start
// S_RUN  | iterating, one quotient bit per cycle
// S_DONE | results just loaded; done pulse; start accepted again here
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_iter;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] t;
  logic [WIDTH-1:0] q_sh;

  assign accept    = start && (state_q != S_RUN);
  assign last_iter = (state_q == S_RUN) && (cnt_q == CW'(1));

  // State register and all datapath flops, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Restoring iteration: shift {R,Q}, trial-subtract D, keep or restore
  always_comb begin
    r_sh  = {r_q, q_q[WIDTH-1]};
    q_sh  = {q_q[WIDTH-2:0], 1'b0};
    t     = r_sh - {2'b00, d_q};
    cnt_d = cnt_q;
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      q_d   = dividend;
      d_d   = divisor;
      r_d   = '0;
      cnt_d = CW'(WIDTH);
    end else if (state_q == S_RUN) begin
      // The sign bit of the widened difference decides restore vs. keep
      if (!t[WIDTH+1]) begin
        r_d = t[WIDTH:0];
        q_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_d = r_sh[WIDTH:0];
        q_d = q_sh;
      end
      cnt_d = cnt_q - CW'(1);
      // Results land on the same edge that enters S_DONE
      if (last_iter) begin
        quo_d = q_d;
        rem_d = r_d[WIDTH-1:0];
        dbz_d = (d_q == '0);
      end
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
